// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU result FIFOs feeding one registered CDB broadcast per cycle,
// chosen round-robin among the non-empty FIFOs.
module cdb_arbiter #(
  parameter int N_FU  = 4,
  parameter int DEPTH = 2,
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [N_FU-1:0]           fu_valid,
  input  logic [N_FU*TAG_W-1:0]     fu_tag,
  input  logic [N_FU*XLEN-1:0]      fu_value,
  output logic [N_FU-1:0]           fu_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [XLEN-1:0]           cdb_value,
  output logic [$clog2(N_FU)-1:0]   cdb_fu
);

  localparam int FU_W  = $clog2(N_FU);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0] count   [N_FU];
  logic [PTR_W-1:0] wr_ptr  [N_FU];
  logic [PTR_W-1:0] rd_ptr  [N_FU];
  logic [TAG_W-1:0] mem_tag   [N_FU][DEPTH];
  logic [XLEN-1:0]  mem_value [N_FU][DEPTH];

  logic [FU_W-1:0]  rr_ptr;
  logic [FU_W-1:0]  rr_next;
  logic [FU_W-1:0]  cand;
  logic [FU_W-1:0]  win_idx;
  logic             win_found;
  logic [N_FU-1:0]  push;
  logic [N_FU-1:0]  pop;
  logic [TAG_W-1:0] head_tag;
  logic [XLEN-1:0]  head_value;

  // Handshake: an FU result transfers at a rising edge when fu_valid[i] && fu_ready[i].
  // fu_ready[i] comes only from the registered count, so a full FIFO refuses a push even
  // while its head is popped in the same cycle; fu_valid never feeds back into fu_ready.
  always_comb begin
    fu_ready = '0;
    push     = '0;
    for (int i = 0; i < N_FU; i++) begin
      fu_ready[i] = (count[i] < CNT_W'(DEPTH));
      push[i]     = fu_valid[i] && fu_ready[i];
    end
  end

  // Round-robin search starting at rr_ptr; first non-empty FIFO wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    pop       = '0;
    for (int k = 0; k < N_FU; k++) begin
      cand = FU_W'((int'(rr_ptr) + k) % N_FU);
      if (!win_found && (count[cand] != '0)) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    if (win_found) begin
      pop[win_idx] = 1'b1;
    end
  end

  always_comb begin
    rr_next    = (win_idx == FU_W'(N_FU - 1)) ? '0 : win_idx + FU_W'(1);
    head_tag   = mem_tag[win_idx][rd_ptr[win_idx]];
    head_value = mem_value[win_idx][rd_ptr[win_idx]];
  end

  // Storage carries no reset; occupancy is tracked entirely by count and the pointers.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_FU; i++) begin
      if (push[i] && !flush) begin
        mem_tag[i][wr_ptr[i]]   <= fu_tag[i*TAG_W +: TAG_W];
        mem_value[i][wr_ptr[i]] <= fu_value[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_FU; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_fu    <= '0;
    end else if (flush) begin
      for (int i = 0; i < N_FU; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < N_FU; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        end
        if (push[i] && !pop[i]) begin
          count[i] <= count[i] + CNT_W'(1);
        end else if (pop[i] && !push[i]) begin
          count[i] <= count[i] - CNT_W'(1);
        end
      end
      cdb_valid <= win_found;
      // Tag/value/fu keep their last broadcast when the bus goes idle.
      if (win_found) begin
        rr_ptr    <= rr_next;
        cdb_tag   <= head_tag;
        cdb_value <= head_value;
        cdb_fu    <= win_idx;
      end
    end
  end

endmodule
